step_timer_ctrl: RTL and testbench
==================================

# step_timer_ctrl

Sequencer for the 16-bit loadable up/down step counter. It loads a preset and issues prescaled count-enable pulses to the counter: down-count for the step timeout, or up-count for the stopwatch. It monitors the counter's terminal-count flags to stop exactly at 0x0000 or 0xFFFF, without wrap, and reports completion. It sits between the game FSM (start/pause/abort commands) and the counter instance.

## Interface
- TICK_DIV, 100000, clock cycles per count tick (≥2); 1 ms at 100 MHz
- clk_i  in  1  system clock, all logic rising-edge
- rst_ni  in  1  reset, asynchronous, active-low
- start_i  in  1  pulse: capture preset_i/mode_i, (re)load and run
- pause_i  in  1  pulse: toggle RUN↔PAUSE; ignored in other states
- abort_i  in  1  pulse: stop, return to IDLE
- mode_i  in  1  0 = down (timeout), 1 = up (stopwatch); sampled with start_i
- preset_i  in  16  load value; sampled with start_i
- cnt_q_i  in  16  counter value (status only)
- cnt_utc_i  in  1  counter at 0xFFFF
- cnt_dtc_i  in  1  counter at 0x0000
- cnt_ld_o  out  1  counter load enable
- cnt_din_o  out  16  counter load data (registered preset)
- cnt_up_o  out  1  counter up-enable, one-cycle pulses
- cnt_dw_o  out  1  counter down-enable, one-cycle pulses
- busy_o  out  1  high in LOAD, RUN, PAUSE
- paused_o  out  1  high in PAUSE
- done_o  out  1  one-cycle pulse on entry to DONE
- expired_o  out  1  level, high while in DONE

## Operation
- States: IDLE, LOAD, RUN, PAUSE, DONE.
- Command priority, sampled each edge: abort_i > start_i > pause_i.
- abort_i: any state goes to IDLE. No load, no count pulse in the following cycle.
- start_i: any state goes to LOAD. preset_i goes to cnt_din_o register and mode_i to the mode register. The prescaler is cleared.
- LOAD: cnt_ld_o = 1 for exactly one cycle, then RUN.
- RUN:
  - Prescaler increments each cycle.
  - tick = (prescaler == TICK_DIV-1). Prescaler wraps to 0 on tick.
  - Down mode: cnt_dw_o = tick & ~cnt_dtc_i.
  - Up mode: cnt_up_o = tick & ~cnt_utc_i.
- Terminal: in RUN, if (down & cnt_dtc_i) or (up & cnt_utc_i), go to DONE at the next edge. This is checked every cycle, not only on tick. No enable is issued that cycle, so the counter never wraps.
- pause_i in RUN goes to PAUSE. The prescaler holds its value and no enables are issued. pause_i in PAUSE goes to RUN, and the prescaler resumes from the held value.
- DONE: remains until start_i or abort_i. pause_i is ignored.
- cnt_up_o and cnt_dw_o are never both high. Neither is high in the same cycle as cnt_ld_o.
- Reset values:
  - state IDLE; prescaler 0; mode 0
  - cnt_din_o 0x0000
  - all 1-bit outputs 0

## Timing
- start_i sampled at edge k:
  - LOAD during cycle k..k+1, with cnt_ld_o = 1.
  - The counter loads at edge k+1; RUN from k+1.
  - The first count pulse is asserted TICK_DIV cycles after RUN entry. The counter steps at that pulse's closing edge.
- Down preset N (N ≥ 1): the last cnt_dw_o takes Q to 0. The FSM sees cnt_dtc_i the next cycle and enters DONE one edge later.
  - done_o is asserted in the cycle after DONE entry is registered: N·TICK_DIV + 2 cycles after RUN entry.
- Preset 0 in down mode, or 0xFFFF in up mode: DONE entered 1 cycle after RUN entry, with no count pulses.
- Enables are combinational from state, prescaler and flags, with no extra register stage. The counter samples them at the same edge.
- start_i while in RUN or PAUSE: restarts immediately. Any in-flight tick in that cycle is suppressed.
- Reset asserted mid-run: all outputs go to their reset values asynchronously. The counter contents are not touched.

## Test plan
- Down run, TICK_DIV=4, preset 3: cnt_ld_o for 1 cycle, then cnt_dw_o pulses every 4 cycles, exactly 3 of them. Q goes 3→2→1→0. done_o is a single pulse, expired_o stays high, and Q holds 0 with no wrap to 0xFFFF.
- Up run, TICK_DIV=4, preset 0xFFFD: 2 cnt_up_o pulses, Q ends at 0xFFFF, DONE is entered, and no third pulse appears.
- Pause/resume, TICK_DIV=4, preset 5:
  - pause_i 2 cycles into the tick period, held in PAUSE 10 cycles: no enables, paused_o high.
  - Resume: the next pulse arrives 2 cycles after resume.
  - Total of 5 pulses before done_o.
- Preset 0 in down mode: LOAD, RUN for 1 cycle, DONE. Zero cnt_dw_o pulses. done_o follows 2 cycles after RUN entry.
- Priority and restart:
  - abort_i and start_i in the same cycle during RUN: IDLE, cnt_ld_o stays 0.
  - start_i during RUN with preset 7: fresh LOAD, with cnt_din_o = 7.
- Async reset: assert rst_ni = 0 mid-RUN between clock edges. All outputs go to 0 immediately. After release, the block is in IDLE with busy_o = 0.

Source files
------------

// File: rtl/step_timer_ctrl_if.sv
// Command and counter-side signals of the step timer sequencer.
// master = game FSM / counter environment, slave = step_timer_ctrl.
interface step_timer_ctrl_if;
    logic        start_i;
    logic        pause_i;
    logic        abort_i;
    logic        mode_i;
    logic [15:0] preset_i;
    logic [15:0] cnt_q_i;
    logic        cnt_utc_i;
    logic        cnt_dtc_i;
    logic        cnt_ld_o;
    logic [15:0] cnt_din_o;
    logic        cnt_up_o;
    logic        cnt_dw_o;
    logic        busy_o;
    logic        paused_o;
    logic        done_o;
    logic        expired_o;

    modport master (
        output start_i, pause_i, abort_i, mode_i, preset_i,
        output cnt_q_i, cnt_utc_i, cnt_dtc_i,
        input  cnt_ld_o, cnt_din_o, cnt_up_o, cnt_dw_o,
        input  busy_o, paused_o, done_o, expired_o
    );

    modport slave (
        input  start_i, pause_i, abort_i, mode_i, preset_i,
        input  cnt_q_i, cnt_utc_i, cnt_dtc_i,
        output cnt_ld_o, cnt_din_o, cnt_up_o, cnt_dw_o,
        output busy_o, paused_o, done_o, expired_o
    );
endinterface

// File: rtl/step_timer_ctrl.sv
// Sequencer for a 16-bit up/down step counter: load preset, prescaled enables, stop at terminal count.
// Latency: load one cycle after start; count enables combinational; done_o one cycle after DONE entry.
// No backpressure: commands are single-cycle pulses, abort > start > pause.
module step_timer_ctrl #(
    parameter int unsigned TICK_DIV = 100000
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    step_timer_ctrl_if.slave  bus
);
    localparam int unsigned PW = $clog2(TICK_DIV);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_PAUSE,
        S_DONE
    } state_t;

    state_t        r_state;
    state_t        w_nxt;
    logic [PW-1:0] r_presc;
    logic          r_mode;
    logic [15:0]   r_din;
    logic          r_ld;
    logic          r_busy;
    logic          r_paused;
    logic          r_done;
    logic          r_expired;
    logic          r_was_done;

    logic          w_tick;
    logic          w_term;
    logic          w_cmd_kill;
    logic          w_run_tick;

    assign w_tick     = (r_presc == PW'(TICK_DIV - 1));
    assign w_term     = (r_state == S_RUN) && (r_mode ? bus.cnt_utc_i : bus.cnt_dtc_i);
    // A start or abort in the same cycle cancels any tick still in flight.
    assign w_cmd_kill = bus.abort_i | bus.start_i;
    assign w_run_tick = (r_state == S_RUN) && w_tick && !w_cmd_kill;

    assign bus.cnt_dw_o  = w_run_tick && !r_mode && !bus.cnt_dtc_i;
    assign bus.cnt_up_o  = w_run_tick &&  r_mode && !bus.cnt_utc_i;
    assign bus.cnt_ld_o  = r_ld;
    assign bus.cnt_din_o = r_din;
    assign bus.busy_o    = r_busy;
    assign bus.paused_o  = r_paused;
    assign bus.done_o    = r_done;
    assign bus.expired_o = r_expired;

    always_comb begin
        w_nxt = r_state;
        if (bus.abort_i) begin
            w_nxt = S_IDLE;
        end else if (bus.start_i) begin
            w_nxt = S_LOAD;
        end else begin
            case (r_state)
                S_LOAD:  w_nxt = S_RUN;
                S_RUN:   if (w_term) w_nxt = S_DONE;
                         else if (bus.pause_i) w_nxt = S_PAUSE;
                S_PAUSE: if (bus.pause_i) w_nxt = S_RUN;
                default: w_nxt = r_state;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= S_IDLE;
            r_presc    <= '0;
            r_mode     <= 1'b0;
            r_din      <= 16'h0000;
            r_ld       <= 1'b0;
            r_busy     <= 1'b0;
            r_paused   <= 1'b0;
            r_done     <= 1'b0;
            r_expired  <= 1'b0;
            r_was_done <= 1'b0;
        end else begin
            r_state    <= w_nxt;
            r_ld       <= (w_nxt == S_LOAD);
            r_busy     <= (w_nxt == S_LOAD) || (w_nxt == S_RUN) || (w_nxt == S_PAUSE);
            r_paused   <= (w_nxt == S_PAUSE);
            r_expired  <= (w_nxt == S_DONE);
            r_was_done <= (r_state == S_DONE);
            // Pulse in the first cycle after DONE has been registered.
            r_done     <= (r_state == S_DONE) && !r_was_done;

            if (bus.abort_i) begin
                r_presc <= '0;
            end else if (bus.start_i) begin
                r_presc <= '0;
                r_din   <= bus.preset_i;
                r_mode  <= bus.mode_i;
            end else if (r_state == S_RUN) begin
                r_presc <= w_tick ? '0 : r_presc + PW'(1);
            end
        end
    end
endmodule

// File: tb/tb_step_timer_ctrl.sv
// Directed bench for step_timer_ctrl (TICK_DIV=4) with a behavioural 16-bit up/down counter attached.
module tb_step_timer_ctrl;
    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;
    int   checks = 0;
    int   errors = 0;

    step_timer_ctrl_if bus();

    step_timer_ctrl #(.TICK_DIV(4)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    always #5 clk_i = ~clk_i;

    // Counter the sequencer drives; deliberately not reset.
    logic [15:0] q = 16'h0000;
    always @(posedge clk_i) begin
        if (bus.cnt_ld_o)      q <= bus.cnt_din_o;
        else if (bus.cnt_up_o) q <= q + 16'd1;
        else if (bus.cnt_dw_o) q <= q - 16'd1;
    end
    assign bus.cnt_q_i   = q;
    assign bus.cnt_utc_i = (q == 16'hFFFF);
    assign bus.cnt_dtc_i = (q == 16'h0000);

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    // Observe n cycles starting at the current one (t = 0).
    task automatic window(input int n, output int n_dw, output int n_up, output int n_ld,
                          output int n_done, output int t_first, output int t_done,
                          output int t_exp, output int overlap);
        n_dw = 0; n_up = 0; n_ld = 0; n_done = 0;
        t_first = -1; t_done = -1; t_exp = -1; overlap = 0;
        for (int t = 0; t < n; t++) begin
            if (bus.cnt_dw_o) begin n_dw++; if (t_first < 0) t_first = t; end
            if (bus.cnt_up_o) begin n_up++; if (t_first < 0) t_first = t; end
            if (bus.cnt_ld_o) n_ld++;
            if (bus.done_o) begin n_done++; if (t_done < 0) t_done = t; end
            if (bus.expired_o && t_exp < 0) t_exp = t;
            if ((bus.cnt_up_o && bus.cnt_dw_o) ||
                ((bus.cnt_up_o || bus.cnt_dw_o) && bus.cnt_ld_o)) overlap++;
            cyc(1);
        end
    endtask

    task automatic start_run(input logic mode, input logic [15:0] preset);
        bus.mode_i   = mode;
        bus.preset_i = preset;
        bus.start_i  = 1'b1;
        cyc(1);
        bus.start_i  = 1'b0;
    endtask

    int n_dw, n_up, n_ld, n_done, t_first, t_done, t_exp, ovl;

    initial begin
        bus.start_i  = 1'b0;
        bus.pause_i  = 1'b0;
        bus.abort_i  = 1'b0;
        bus.mode_i   = 1'b0;
        bus.preset_i = 16'h0000;

        // Reset state
        #7;
        chk("rst_outs", {25'd0, bus.cnt_ld_o, bus.cnt_up_o, bus.cnt_dw_o, bus.busy_o,
                         bus.paused_o, bus.done_o, bus.expired_o}, 32'h0);
        chk("rst_din", {16'd0, bus.cnt_din_o}, 32'h0);
        #15 rst_ni = 1'b1;
        cyc(1);
        chk("idle_busy", {31'd0, bus.busy_o}, 32'h0);

        // Down run, preset 3
        start_run(1'b0, 16'd3);
        chk("dn_ld", {31'd0, bus.cnt_ld_o}, 32'h1);
        chk("dn_din", {16'd0, bus.cnt_din_o}, 32'd3);
        chk("dn_busy", {31'd0, bus.busy_o}, 32'h1);
        cyc(1);
        window(20, n_dw, n_up, n_ld, n_done, t_first, t_done, t_exp, ovl);
        chk("dn_npulse", n_dw, 32'd3);
        chk("dn_nup", n_up, 32'd0);
        chk("dn_nld", n_ld, 32'd0);
        chk("dn_first", t_first, 32'd3);
        chk("dn_exp_t", t_exp, 32'd13);
        chk("dn_done_t", t_done, 32'd14);
        chk("dn_ndone", n_done, 32'd1);
        chk("dn_overlap", ovl, 32'd0);
        chk("dn_expired", {31'd0, bus.expired_o}, 32'h1);
        chk("dn_q_hold", {16'd0, q}, 32'h0);

        // Up run, preset 0xFFFD
        start_run(1'b1, 16'hFFFD);
        cyc(1);
        window(20, n_dw, n_up, n_ld, n_done, t_first, t_done, t_exp, ovl);
        chk("up_npulse", n_up, 32'd2);
        chk("up_ndw", n_dw, 32'd0);
        chk("up_first", t_first, 32'd3);
        chk("up_done_t", t_done, 32'd10);
        chk("up_q", {16'd0, q}, 32'hFFFF);
        chk("up_expired", {31'd0, bus.expired_o}, 32'h1);

        // Pause after two prescaler cycles, hold 10, resume
        start_run(1'b0, 16'd5);
        cyc(2);
        bus.pause_i = 1'b1;
        cyc(1);
        bus.pause_i = 1'b0;
        chk("pz_paused", {31'd0, bus.paused_o}, 32'h1);
        chk("pz_busy", {31'd0, bus.busy_o}, 32'h1);
        window(10, n_dw, n_up, n_ld, n_done, t_first, t_done, t_exp, ovl);
        chk("pz_noen", n_dw + n_up, 32'd0);
        chk("pz_still", {31'd0, bus.paused_o}, 32'h1);
        chk("pz_q", {16'd0, q}, 32'd5);
        bus.pause_i = 1'b1;
        cyc(1);
        bus.pause_i = 1'b0;
        chk("pz_resumed", {31'd0, bus.paused_o}, 32'h0);
        window(24, n_dw, n_up, n_ld, n_done, t_first, t_done, t_exp, ovl);
        chk("pz_first", t_first, 32'd1);
        chk("pz_npulse", n_dw, 32'd5);
        chk("pz_done_t", t_done, 32'd20);
        chk("pz_q_end", {16'd0, q}, 32'h0);
        bus.pause_i = 1'b1;
        cyc(1);
        bus.pause_i = 1'b0;
        chk("done_pause_ign", {30'd0, bus.expired_o, bus.paused_o}, 32'h2);

        // Preset 0 in down mode
        start_run(1'b0, 16'd0);
        chk("z_ld", {31'd0, bus.cnt_ld_o}, 32'h1);
        cyc(1);
        window(6, n_dw, n_up, n_ld, n_done, t_first, t_done, t_exp, ovl);
        chk("z_npulse", n_dw + n_up, 32'd0);
        chk("z_exp_t", t_exp, 32'd1);
        chk("z_done_t", t_done, 32'd2);

        // abort + start together on a tick cycle
        start_run(1'b0, 16'd9);
        cyc(4);
        chk("ab_tick", {31'd0, bus.cnt_dw_o}, 32'h1);
        bus.abort_i  = 1'b1;
        bus.start_i  = 1'b1;
        bus.preset_i = 16'd7;
        #1;
        chk("ab_sup", {31'd0, bus.cnt_dw_o}, 32'h0);
        cyc(1);
        bus.abort_i = 1'b0;
        bus.start_i = 1'b0;
        chk("ab_ld", {31'd0, bus.cnt_ld_o}, 32'h0);
        chk("ab_busy", {31'd0, bus.busy_o}, 32'h0);
        chk("ab_q", {16'd0, q}, 32'd9);
        chk("ab_din", {16'd0, bus.cnt_din_o}, 32'd9);
        window(3, n_dw, n_up, n_ld, n_done, t_first, t_done, t_exp, ovl);
        chk("ab_quiet", n_ld + n_dw + n_up, 32'd0);

        // Restart during RUN with preset 7
        start_run(1'b0, 16'd9);
        cyc(4);
        chk("rs_tick", {31'd0, bus.cnt_dw_o}, 32'h1);
        bus.preset_i = 16'd7;
        bus.start_i  = 1'b1;
        #1;
        chk("rs_sup", {31'd0, bus.cnt_dw_o}, 32'h0);
        cyc(1);
        bus.start_i = 1'b0;
        chk("rs_ld", {31'd0, bus.cnt_ld_o}, 32'h1);
        chk("rs_din", {16'd0, bus.cnt_din_o}, 32'd7);
        chk("rs_q_kept", {16'd0, q}, 32'd9);
        cyc(1);
        chk("rs_q_load", {16'd0, q}, 32'd7);
        window(34, n_dw, n_up, n_ld, n_done, t_first, t_done, t_exp, ovl);
        chk("rs_npulse", n_dw, 32'd7);
        chk("rs_done_t", t_done, 32'd30);

        // Async reset mid-run on a tick cycle
        start_run(1'b0, 16'd5);
        cyc(4);
        chk("ar_tick", {31'd0, bus.cnt_dw_o}, 32'h1);
        #2 rst_ni = 1'b0;
        #1;
        chk("ar_outs", {25'd0, bus.cnt_ld_o, bus.cnt_up_o, bus.cnt_dw_o, bus.busy_o,
                        bus.paused_o, bus.done_o, bus.expired_o}, 32'h0);
        chk("ar_din", {16'd0, bus.cnt_din_o}, 32'h0);
        #3 rst_ni = 1'b1;
        cyc(1);
        chk("ar_idle", {30'd0, bus.busy_o, bus.cnt_ld_o}, 32'h0);
        chk("ar_q", {16'd0, q}, 32'd5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
